// File: rtl/fifo_nibble_packer.sv
// Pops 4-bit nibbles from a synchronous FIFO and packs NIBBLES of them LSB-first
// into one output word, presented on a valid/ready handshake; flush emits a zero-padded partial word.
module fifo_nibble_packer #(
    parameter int NIBBLES = 4,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [3:0]           fifo_dout,
    output logic                 fifo_rd_en,
    input  logic                 flush,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [4*NIBBLES-1:0] out_data,
    output logic [CW-1:0]        out_nib_cnt
);
    localparam int              W        = 4 * NIBBLES;
    localparam logic [CW-1:0]   FULL_CNT = CW'(NIBBLES);
    localparam logic [CW:0]     FULL_EXT = (CW+1)'(NIBBLES);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CW:0]    fill_level;
    logic           pending_q;
    logic           flush_req_q, flush_req_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   data_q, data_d;
    logic [CW-1:0]  nib_cnt_q, nib_cnt_d;
    logic           valid_q, valid_d;

    // Clears every nibble slot at or above n so a partial word carries zero padding.
    function automatic logic [W-1:0] pad_word(input logic [W-1:0] word, input logic [CW-1:0] n);
        logic [W-1:0] res;
        res = word;
        for (int k = 0; k < NIBBLES; k++) begin
            if (CW'(k) >= n) res[4*k +: 4] = 4'h0;
        end
        return res;
    endfunction

    // A pop already in flight counts against the word so the last slot is never overrun.
    assign fill_level = {1'b0, cnt_q} + {{CW{1'b0}}, pending_q};
    assign cnt_inc    = cnt_q + 1'b1;
    assign fifo_rd_en = !rst && (state_q == FILL) && !fifo_empty && !flush_req_q
                        && (fill_level < FULL_EXT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        data_d      = data_q;
        nib_cnt_d   = nib_cnt_q;
        valid_d     = valid_q;
        flush_req_d = flush_req_q | flush;
        case (state_q)
            FILL: begin
                if (pending_q) begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (CW'(k) == cnt_q) acc_d[4*k +: 4] = fifo_dout;
                    end
                    if (cnt_inc == FULL_CNT) begin
                        data_d    = acc_d;
                        nib_cnt_d = FULL_CNT;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (flush_req_q) begin
                    // No pop in flight: the flush can be served now.
                    flush_req_d = flush;
                    if (cnt_q != '0) begin
                        data_d    = pad_word(acc_q, cnt_q);
                        nib_cnt_d = cnt_q;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                        cnt_d     = '0;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            nib_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= fifo_rd_en;
            flush_req_q <= flush_req_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            nib_cnt_q   <= nib_cnt_d;
        end
    end

    // Slot accumulator; unused slots are masked on output, so no reset is needed.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_nib_cnt = nib_cnt_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: a FIFO model feeds the DUT; every accepted word is
// scored against the ordered stream of popped nibbles, plus directed corner cases.
module tb_fifo_nibble_packer;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [3:0]   fifo_dout = 4'h0;
    logic         fifo_rd_en;
    logic         flush;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   out_nib_cnt;

    fifo_nibble_packer #(.NIBBLES(NIB), .CW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_nib_cnt (out_nib_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: contents in nib_mem, read data one cycle after a granted pop.
    logic [3:0] nib_mem [0:4095];
    int pushed_n = 0;
    int popped_n = 0;
    assign fifo_empty = (pushed_n == popped_n);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= nib_mem[popped_n[11:0]];
            popped_n  <= popped_n + 1;
        end
    end

    typedef struct {
        logic [15:0] nibs;      // first nibble to push in the top hex digit
        int          n;
        int          gap;
        bit          do_flush;
        logic [15:0] exp_data;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t        vecs [6];
    logic [3:0]  exp_q [$];
    bit          flush_seen = 1'b0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = '0;
    logic [3:0]  prev_cnt = '0;
    logic [15:0] last_data = '0;
    logic [3:0]  last_cnt = '0;
    int          words_rx = 0;
    int          first_rd = -1;
    int          first_vld = -1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          npre;
    int          w0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] v);
        nib_mem[pushed_n[11:0]] = v;
        pushed_n++;
    endtask

    // Per-cycle monitor: invariants, latency stamps and the word scoreboard.
    task automatic mon();
        logic [15:0] ew;
        chk(!(fifo_rd_en && fifo_empty), "rd_en_while_empty", int'(fifo_rd_en), 0);
        chk(!(fifo_rd_en && out_valid), "rd_en_while_holding", int'(fifo_rd_en), 0);
        if (prev_hold)
            chk(out_valid && out_data == prev_data && out_nib_cnt == prev_cnt,
                "held_word_stable", int'(out_data), int'(prev_data));
        if (first_rd < 0 && fifo_rd_en) first_rd = cyc;
        if (first_vld < 0 && out_valid && !rst) first_vld = cyc;
        if (out_valid && out_ready && !rst) begin
            ew = '0;
            for (int k = 0; k < NIB; k++)
                if (k < int'(out_nib_cnt) && k < exp_q.size()) ew[4*k +: 4] = exp_q[k];
            chk(int'(out_nib_cnt) == exp_q.size(), "nib_cnt_vs_model",
                int'(out_nib_cnt), exp_q.size());
            chk(int'(out_nib_cnt) == NIB || flush_seen, "partial_without_flush",
                int'(out_nib_cnt), NIB);
            chk(out_data == ew, "word_data", int'(out_data), int'(ew));
            for (int k = 0; k < int'(out_nib_cnt) && exp_q.size() > 0; k++)
                void'(exp_q.pop_front());
            words_rx++;
            last_data  = out_data;
            last_cnt   = out_nib_cnt;
            flush_seen = 1'b0;
        end
        if (flush && !rst) flush_seen = 1'b1;
        if (fifo_rd_en && !fifo_empty) exp_q.push_back(nib_mem[popped_n[11:0]]);
        if (rst) begin
            exp_q.delete();
            flush_seen = 1'b0;
        end
        prev_hold = out_valid && !out_ready && !rst;
        prev_data = out_data;
        prev_cnt  = out_nib_cnt;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input int bound);
        int start;
        int i;
        start = words_rx;
        i = 0;
        while (words_rx == start && i < bound) begin
            step();
            i++;
        end
        chk(words_rx != start, "word_timeout", i, bound);
    endtask

    task automatic wait_valid(input int bound);
        int i;
        i = 0;
        while (!out_valid && i < bound) begin
            step();
            i++;
        end
        chk(out_valid, "valid_timeout", i, bound);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4, 0, 1'b0, 16'h4321, 4'd4};
        vecs[1] = '{16'hABCD, 4, 6, 1'b0, 16'hDCBA, 4'd4};
        vecs[2] = '{16'h9E50, 3, 0, 1'b1, 16'h05E9, 4'd3};
        vecs[3] = '{16'h7F00, 2, 3, 1'b1, 16'h00F7, 4'd2};
        vecs[4] = '{16'hC000, 1, 0, 1'b1, 16'h000C, 4'd1};
        vecs[5] = '{16'h5A5A, 4, 0, 1'b0, 16'hA5A5, 4'd4};

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;

        // Reset with a non-empty FIFO: nothing may be popped.
        for (int k = 1; k <= 8; k++) push(4'(k));
        step();
        step();
        chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
        chk(out_data == '0, "reset_out_data", int'(out_data), 0);
        chk(out_nib_cnt == '0, "reset_out_nib_cnt", int'(out_nib_cnt), 0);
        chk(fifo_rd_en == 1'b0, "reset_rd_en", int'(fifo_rd_en), 0);

        // Streaming two words with the minimum latency.
        rst = 1'b0;
        out_ready = 1'b1;
        first_rd = -1;
        first_vld = -1;
        wait_word(30);
        chk(last_data == 16'h4321, "stream_word0", int'(last_data), 16'h4321);
        chk(last_cnt == 4'd4, "stream_cnt0", int'(last_cnt), 4);
        chk(first_vld - first_rd == NIB + 1, "stream_latency", first_vld - first_rd, NIB + 1);
        wait_word(30);
        chk(last_data == 16'h8765, "stream_word1", int'(last_data), 16'h8765);

        // Backpressure: a held word stays put and blocks pops.
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) push(4'(k));
        wait_valid(30);
        for (int i = 0; i < 10; i++) begin
            chk(out_valid && out_data == 16'h4321, "bp_held_data", int'(out_data), 16'h4321);
            chk(fifo_rd_en == 1'b0, "bp_rd_en", int'(fifo_rd_en), 0);
            step();
        end
        w0 = words_rx;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        chk(words_rx == w0 + 1, "bp_single_handshake", words_rx - w0, 1);
        chk(last_data == 16'h4321, "bp_word0", int'(last_data), 16'h4321);
        out_ready = 1'b1;
        wait_word(30);
        chk(last_data == 16'h8765, "bp_word1", int'(last_data), 16'h8765);

        // Table: full words, empty stalls, flushed partial words.
        for (int v = 0; v < 6; v++) begin
            npre = (vecs[v].n < 2) ? vecs[v].n : 2;
            for (int k = 0; k < npre; k++) push(vecs[v].nibs[15-4*k -: 4]);
            if (vecs[v].gap > 0) begin
                repeat (vecs[v].gap) step();
                chk(popped_n == pushed_n, "stall_drained", popped_n, pushed_n);
                chk(out_valid == 1'b0, "stall_no_word", int'(out_valid), 0);
            end
            for (int k = npre; k < vecs[v].n; k++) push(vecs[v].nibs[15-4*k -: 4]);
            if (vecs[v].do_flush) begin
                repeat (6) step();
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
            wait_word(40);
            chk(last_data == vecs[v].exp_data, "vec_data", int'(last_data), int'(vecs[v].exp_data));
            chk(last_cnt == vecs[v].exp_cnt, "vec_cnt", int'(last_cnt), int'(vecs[v].exp_cnt));
        end

        // Flush with nothing captured produces no word.
        w0 = words_rx;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (8) step();
        chk(words_rx == w0, "empty_flush_words", words_rx - w0, 0);
        chk(out_valid == 1'b0, "empty_flush_valid", int'(out_valid), 0);

        // Flush latched during HOLD is served after the handshake with nothing to emit.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push(4'(k));
        wait_valid(30);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();
        out_ready = 1'b1;
        wait_word(10);
        chk(last_data == 16'h4321, "hold_flush_word", int'(last_data), 16'h4321);
        for (int k = 5; k <= 8; k++) push(4'(k));
        wait_word(30);
        chk(last_data == 16'h8765, "hold_flush_next", int'(last_data), 16'h8765);
        chk(last_cnt == 4'd4, "hold_flush_next_cnt", int'(last_cnt), 4);

        // Reset after two captures: the next word holds only post-reset nibbles.
        push(4'h1);
        push(4'h2);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 3; k <= 6; k++) push(4'(k));
        wait_word(30);
        chk(last_data == 16'h6543, "reset_mid_word", int'(last_data), 16'h6543);

        // Random traffic scored by the monitor.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2) == 0) push(4'($urandom));
            out_ready = ($urandom_range(1) == 1);
            flush = ($urandom_range(19) == 0);
            rst = ($urandom_range(149) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && pushed_n != popped_n; i++) step();
        chk(pushed_n == popped_n, "drain_fifo", popped_n, pushed_n);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        chk(exp_q.size() == 0, "drain_model_empty", exp_q.size(), 0);
        chk(out_valid == 1'b0, "drain_idle", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
